// File: rtl/frame_ecc_walker.sv
// frame_ecc_walker: walks every configuration frame once per scrub trigger,
// reads each frame back, and acts on its ECC verdict. A single-bit error
// triggers a correction write. Errors are tallied in saturating counters,
// and sticky alarms are kept for the health monitor.
module frame_ecc_walker #(
  parameter int NUM_FRAMES = 4096,
  parameter int FRAME_AW   = 12,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic                scrub_start,
  output logic                frm_req,
  output logic [FRAME_AW-1:0] frm_addr,
  input  logic                frm_ack,
  input  logic                ecc_valid,
  input  logic                ecc_sbe,
  input  logic                ecc_dbe,
  input  logic [11:0]         ecc_loc,
  output logic                fix_req,
  output logic [FRAME_AW-1:0] fix_addr,
  output logic [11:0]         fix_loc,
  input  logic                fix_ack,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sbe_count,
  output logic [CNT_W-1:0]    dbe_count,
  output logic                dbe_alarm,
  output logic                timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // The timer only has to reach TIMEOUT-1. The block leaves WAIT on the
  // edge that ends the TIMEOUT-th cycle spent in WAIT.
  localparam int                TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [FRAME_AW-1:0] LAST_ADDR = FRAME_AW'(NUM_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [2:0]          r_state;
  logic [TMR_W-1:0]    r_timer;
  logic                r_frm_req;
  logic [FRAME_AW-1:0] r_frm_addr;
  logic                r_fix_req;
  logic [FRAME_AW-1:0] r_fix_addr;
  logic [11:0]         r_fix_loc;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_sbe_count;
  logic [CNT_W-1:0]    r_dbe_count;
  logic                r_dbe_alarm;
  logic                r_timeout_err;

  logic w_start;
  logic w_verdict;
  logic w_dbe_hit;
  logic w_sbe_hit;
  logic w_timeout;
  logic w_wait_entry;

  // A DBE flag always wins over SBE, so a frame with both flags set is
  // treated as uncorrectable and no fix is issued.
  assign w_start      = (r_state == S_IDLE) && scrub_start;
  assign w_verdict    = (r_state == S_WAIT) && ecc_valid;
  assign w_dbe_hit    = w_verdict && ecc_dbe;
  assign w_sbe_hit    = w_verdict && ecc_sbe && !ecc_dbe;
  assign w_timeout    = (r_state == S_WAIT) && !ecc_valid && (r_timer == TMR_LAST);
  assign w_wait_entry = (r_state == S_REQ) && frm_ack;

  // Main sequencer: state, the readback/fix handshakes, busy/done and frame address.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_frm_req  <= 1'b0;
      r_frm_addr <= '0;
      r_fix_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (scrub_start) begin
          r_state    <= S_REQ;
          r_busy     <= 1'b1;
          r_frm_req  <= 1'b1;
          r_frm_addr <= '0;
        end
        S_REQ: if (frm_ack) begin
          r_frm_req <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (w_sbe_hit) begin
            r_fix_req <= 1'b1;
            r_state   <= S_FIX;
          end else if (w_verdict || w_timeout) begin
            r_state <= S_NEXT;
          end
        end
        S_FIX: if (fix_ack) begin
          r_fix_req <= 1'b0;
          r_state   <= S_NEXT;
        end
        S_NEXT: begin
          if (r_frm_addr == LAST_ADDR) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_frm_addr <= r_frm_addr + FRAME_AW'(1);
            r_frm_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Verdict timer: cleared on entry to WAIT, counts every cycle spent in WAIT.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_wait_entry) begin
      r_timer <= '0;
    end else if (r_state == S_WAIT) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Per-pass error statistics: cleared by an accepted start, saturating, sticky alarms.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sbe_count   <= '0;
      r_dbe_count   <= '0;
      r_dbe_alarm   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_start) begin
      r_sbe_count   <= '0;
      r_dbe_count   <= '0;
      r_dbe_alarm   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_sbe_hit && (r_sbe_count != CNT_MAX)) begin
        r_sbe_count <= r_sbe_count + CNT_W'(1);
      end
      if (w_dbe_hit) begin
        r_dbe_alarm <= 1'b1;
        if (r_dbe_count != CNT_MAX) begin
          r_dbe_count <= r_dbe_count + CNT_W'(1);
        end
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Correction target: captured when an SBE verdict is accepted, held until the next one.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_fix_addr <= '0;
      r_fix_loc  <= '0;
    end else if (w_sbe_hit) begin
      r_fix_addr <= r_frm_addr;
      r_fix_loc  <= ecc_loc;
    end
  end

  assign frm_req     = r_frm_req;
  assign frm_addr    = r_frm_addr;
  assign fix_req     = r_fix_req;
  assign fix_addr    = r_fix_addr;
  assign fix_loc     = r_fix_loc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sbe_count   = r_sbe_count;
  assign dbe_count   = r_dbe_count;
  assign dbe_alarm   = r_dbe_alarm;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_ecc_walker.sv
// Directed bench for frame_ecc_walker. It uses a 4-frame, TIMEOUT=8 instance
// plus a second instance with a 2-bit counter width, and both instances share
// the same stimulus so that counter saturation can be observed.
module tb_frame_ecc_walker;

  localparam int NF  = 4;
  localparam int AW  = 12;
  localparam int CW  = 16;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, scrub_start, frm_ack, ecc_valid, ecc_sbe, ecc_dbe, fix_ack;
  logic [11:0]   ecc_loc;
  logic          frm_req, fix_req, busy, done, dbe_alarm, timeout_err;
  logic [AW-1:0] frm_addr, fix_addr;
  logic [11:0]   fix_loc;
  logic [CW-1:0] sbe_count, dbe_count;

  logic          s_frm_req, s_fix_req, s_busy, s_done, s_dbe_alarm, s_timeout_err;
  logic [AW-1:0] s_frm_addr, s_fix_addr;
  logic [11:0]   s_fix_loc;
  logic [1:0]    s_sbe_count, s_dbe_count;

  frame_ecc_walker #(.NUM_FRAMES(NF), .FRAME_AW(AW), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .scrub_start(scrub_start),
    .frm_req(frm_req), .frm_addr(frm_addr), .frm_ack(frm_ack),
    .ecc_valid(ecc_valid), .ecc_sbe(ecc_sbe), .ecc_dbe(ecc_dbe), .ecc_loc(ecc_loc),
    .fix_req(fix_req), .fix_addr(fix_addr), .fix_loc(fix_loc), .fix_ack(fix_ack),
    .busy(busy), .done(done), .sbe_count(sbe_count), .dbe_count(dbe_count),
    .dbe_alarm(dbe_alarm), .timeout_err(timeout_err)
  );

  frame_ecc_walker #(.NUM_FRAMES(NF), .FRAME_AW(AW), .CNT_W(2), .TIMEOUT(TMO)) dut_sat (
    .clk_100mhz(clk), .rst_n(rst_n), .scrub_start(scrub_start),
    .frm_req(s_frm_req), .frm_addr(s_frm_addr), .frm_ack(frm_ack),
    .ecc_valid(ecc_valid), .ecc_sbe(ecc_sbe), .ecc_dbe(ecc_dbe), .ecc_loc(ecc_loc),
    .fix_req(s_fix_req), .fix_addr(s_fix_addr), .fix_loc(s_fix_loc), .fix_ack(fix_ack),
    .busy(s_busy), .done(s_done), .sbe_count(s_sbe_count), .dbe_count(s_dbe_count),
    .dbe_alarm(s_dbe_alarm), .timeout_err(s_timeout_err)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int fix_cyc   = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (fix_req) fix_cyc = fix_cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass;
    scrub_start = 1'b1;
    start_cyc   = cyc;
    tick();
    scrub_start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_req", 32'(frm_req), 32'd1);
    check_eq("start_addr", 32'(frm_addr), 32'd0);
  endtask

  // mode: 0 clean, 1 sbe, 2 dbe, 3 sbe+dbe, 4 no verdict (timeout).
  // Entered in the first REQ cycle of frame f; returns in its NEXT cycle.
  task automatic do_frame(input int f, input int mode, input logic [11:0] loc, input logic poke);
    $display("frame %0d mode %0d", f, mode);
    check_eq("frm_req_hi", 32'(frm_req), 32'd1);
    check_eq("frm_addr", 32'(frm_addr), 32'(f));
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    check_eq("frm_req_lo", 32'(frm_req), 32'd0);
    if (mode == 4) begin
      repeat (TMO - 1) tick();
      check_eq("tmo_early", 32'(timeout_err), 32'd0);
      tick();
      check_eq("tmo_set", 32'(timeout_err), 32'd1);
    end else begin
      ecc_valid   = 1'b1;
      ecc_sbe     = (mode == 1) || (mode == 3);
      ecc_dbe     = (mode == 2) || (mode == 3);
      ecc_loc     = loc;
      scrub_start = poke;
      tick();
      ecc_valid   = 1'b0;
      ecc_sbe     = 1'b0;
      ecc_dbe     = 1'b0;
      scrub_start = 1'b0;
      if (mode == 1) begin
        check_eq("fix_req_c1", 32'(fix_req), 32'd1);
        check_eq("fix_addr", 32'(fix_addr), 32'(f));
        check_eq("fix_loc", 32'(fix_loc), 32'(loc));
        tick();
        check_eq("fix_req_c2", 32'(fix_req), 32'd1);
        tick();
        check_eq("fix_req_c3", 32'(fix_req), 32'd1);
        fix_ack = 1'b1;
        tick();
        fix_ack = 1'b0;
        check_eq("fix_req_lo", 32'(fix_req), 32'd0);
      end else begin
        check_eq("no_fix", 32'(fix_req), 32'd0);
      end
    end
  endtask

  task automatic end_pass;
    tick();
    check_eq("done_hi", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd1);
    tick();
    check_eq("done_lo", 32'(done), 32'd0);
    check_eq("busy_lo", 32'(busy), 32'd0);
  endtask

  task automatic run_pass(input int m0, input int m1, input int m2, input int m3,
                          input logic [11:0] loc, input int poke_frame);
    int modes [4];
    modes = '{m0, m1, m2, m3};
    start_pass();
    for (int f = 0; f < NF; f++) begin
      do_frame(f, modes[f], loc, (f == poke_frame));
      if (f < NF - 1) tick();
    end
    end_pass();
  endtask

  initial begin
    int d0, f0;
    rst_n = 1'b0; scrub_start = 1'b0; frm_ack = 1'b0; ecc_valid = 1'b0;
    ecc_sbe = 1'b0; ecc_dbe = 1'b0; ecc_loc = '0; fix_ack = 1'b0;
    repeat (3) tick();
    check_eq("rst_frm_req", 32'(frm_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fix_req", 32'(fix_req), 32'd0);
    check_eq("rst_counts", 32'({sbe_count, dbe_count}), 32'd0);
    check_eq("rst_alarms", 32'({dbe_alarm, timeout_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean pass
    d0 = done_cnt; f0 = fix_cyc;
    run_pass(0, 0, 0, 0, 12'h000, -1);
    check_eq("clean_done_lat", 32'(done_cyc - start_cyc), 32'd13);
    check_eq("clean_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("clean_no_fix", 32'(fix_cyc - f0), 32'd0);
    check_eq("clean_sbe", 32'(sbe_count), 32'd0);
    check_eq("clean_dbe", 32'(dbe_count), 32'd0);

    // SBE on frame 2
    f0 = fix_cyc;
    run_pass(0, 0, 1, 0, 12'h5A3, -1);
    check_eq("sbe_fix_cycles", 32'(fix_cyc - f0), 32'd3);
    check_eq("sbe_count", 32'(sbe_count), 32'd1);
    check_eq("sbe_dbe0", 32'(dbe_count), 32'd0);
    check_eq("sbe_alarm0", 32'(dbe_alarm), 32'd0);
    check_eq("sbe_fix_addr_hold", 32'(fix_addr), 32'd2);
    check_eq("sbe_fix_loc_hold", 32'(fix_loc), 32'h5A3);

    // SBE and DBE together on frame 1
    f0 = fix_cyc;
    run_pass(0, 3, 0, 0, 12'h0F0, -1);
    check_eq("both_no_fix", 32'(fix_cyc - f0), 32'd0);
    check_eq("both_sbe0", 32'(sbe_count), 32'd0);
    check_eq("both_dbe1", 32'(dbe_count), 32'd1);
    check_eq("both_alarm", 32'(dbe_alarm), 32'd1);

    // Timeout on frame 0, with a stray start during frame 1
    d0 = done_cnt;
    run_pass(4, 0, 0, 0, 12'h000, 1);
    check_eq("tmo_sticky", 32'(timeout_err), 32'd1);
    check_eq("tmo_dbe_cleared", 32'(dbe_count), 32'd0);
    check_eq("tmo_alarm_cleared", 32'(dbe_alarm), 32'd0);
    check_eq("tmo_done_cnt", 32'(done_cnt - d0), 32'd1);

    // A new start after done clears the timeout alarm
    run_pass(0, 0, 0, 0, 12'h000, -1);
    check_eq("restart_tmo_clr", 32'(timeout_err), 32'd0);

    // All frames DBE: the 2-bit counter saturates at 3
    run_pass(2, 2, 2, 2, 12'h000, -1);
    check_eq("sat_dbe_wide", 32'(dbe_count), 32'd4);
    check_eq("sat_dbe_narrow", 32'(s_dbe_count), 32'd3);
    check_eq("sat_alarm", 32'(s_dbe_alarm), 32'd1);

    // Reset during FIX aborts the pass
    start_pass();
    do_frame(0, 0, 12'h000, 1'b0);
    tick();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    ecc_valid = 1'b1; ecc_sbe = 1'b1; ecc_loc = 12'h3C7;
    tick();
    ecc_valid = 1'b0; ecc_sbe = 1'b0;
    check_eq("pre_rst_fix", 32'(fix_req), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("arst_fix_req", 32'(fix_req), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_addr", 32'({fix_addr, frm_addr}), 32'd0);
    check_eq("arst_fix_loc", 32'(fix_loc), 32'd0);
    check_eq("arst_sbe", 32'(sbe_count), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check_eq("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("post_rst_idle", 32'({busy, frm_req}), 32'd0);

    // The block still runs a normal pass after reset
    run_pass(0, 0, 0, 0, 12'h000, -1);
    check_eq("post_rst_done", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
